// File: rtl/ibex_register_file_scanner.sv
// rtl/ibex_register_file_scanner.sv - sequential register file reader with stream output and rotate-XOR signature
//
// Walks x0..x(NUM_WORDS-1) through a single register file read port, presents
// each word with its index on a valid/ready stream, and accumulates a
// rotate-left-by-one XOR signature over the whole file.
//
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   start_i        begin a scan (sampled only while idle)
//   abort_i        cancel a scan in progress
//   rd_req_o       read port request
//   rd_gnt_i       read port grant; rdata_i valid for raddr_o this cycle
//   raddr_o        read address
//   rdata_i        read data
//   data_valid_o   output word valid
//   data_ready_i   downstream accepts the word
//   data_o         captured register value
//   idx_o          register index of data_o
//   busy_o         scan in progress
//   done_o         one-cycle pulse at the end of a full scan
//   signature_o    running signature, held between scans

module ibex_register_file_scanner #(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  output logic                 rd_req_o,
  input  logic                 rd_gnt_i,
  output logic [4:0]           raddr_o,
  input  logic [DataWidth-1:0] rdata_i,
  output logic                 data_valid_o,
  input  logic                 data_ready_i,
  output logic [DataWidth-1:0] data_o,
  output logic [4:0]           idx_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [DataWidth-1:0] signature_o
);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StSend,
    StDone
  } state_e;

  localparam logic [4:0] LastIdx = RV32E ? 5'd15 : 5'd31;

  state_e               state_q;
  logic [4:0]           idx_q;
  logic [DataWidth-1:0] data_q;
  logic [DataWidth-1:0] sig_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= 5'd0;
      data_q  <= '0;
      sig_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          // abort_i is irrelevant here: a start always wins while idle.
          if (start_i) begin
            idx_q   <= 5'd0;
            sig_q   <= '0;
            state_q <= StRead;
          end
        end
        StRead: begin
          if (abort_i) begin
            state_q <= StIdle;
          end else if (rd_gnt_i) begin
            data_q  <= rdata_i;
            sig_q   <= {sig_q[DataWidth-2:0], sig_q[DataWidth-1]} ^ rdata_i;
            state_q <= StSend;
          end
        end
        StSend: begin
          // data_q and idx_q are untouched here until the handshake, so the
          // presented word stays stable under backpressure.
          if (abort_i) begin
            state_q <= StIdle;
          end else if (data_ready_i) begin
            if (idx_q == LastIdx) begin
              state_q <= StDone;
            end else begin
              idx_q   <= idx_q + 5'd1;
              state_q <= StRead;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // All outputs decode directly from registered state; no input reaches an
  // output combinationally.
  assign rd_req_o     = (state_q == StRead);
  assign raddr_o      = {(RV32E ? 1'b0 : idx_q[4]), idx_q[3:0]};
  assign data_valid_o = (state_q == StSend);
  assign data_o       = data_q;
  assign idx_o        = idx_q;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);
  assign signature_o  = sig_q;

endmodule
